// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the in-order
// writeback stage and a long-latency unit. Completed long-latency results sit in
// a 2-entry FIFO. A per-register pending scoreboard drives the decode stall.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_wa,
    input  logic [XLEN-1:0] pipe_wd,
    input  logic            lu_issue,
    input  logic [4:0]      lu_issue_rd,
    input  logic            lu_valid,
    input  logic [4:0]      lu_wa,
    input  logic [XLEN-1:0] lu_wd,
    output logic            lu_ready,
    input  logic [4:0]      dec_ra1,
    input  logic [4:0]      dec_ra2,
    input  logic [4:0]      dec_rd,
    input  logic            dec_valid,
    output logic            stall,
    output logic            wb_hold,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [31:0]     pend;
    logic [31:0]     pend_nxt;
    logic [4:0]      fifo_wa [2];
    logic [XLEN-1:0] fifo_wd [2];
    logic [1:0]      count;
    logic [SW-1:0]   starve;

    logic has_entry;
    logic starved;
    logic pipe_live;
    logic sel_pipe;
    logic pop;
    logic push;
    logic push_idx;
    logic hazard;

    assign has_entry = (count != 2'd0);
    assign starved   = has_entry && (starve == SW'(STARVE_LIMIT));
    assign pipe_live = pipe_we && (pipe_wa != 5'd0);
    assign sel_pipe  = pipe_live && !starved;
    assign pop       = !reset && has_entry && !sel_pipe;
    assign lu_ready  = !reset && (count < 2'd2);
    // Results targeting x0 are acknowledged but never stored.
    assign push      = lu_valid && lu_ready && (lu_wa != 5'd0);
    // A push slides into the slot just vacated when a pop happens alongside it.
    assign push_idx  = pop ? 1'b0 : count[0];

    assign hazard = dec_valid && (((dec_ra1 != 5'd0) && pend[dec_ra1]) ||
                                  ((dec_ra2 != 5'd0) && pend[dec_ra2]) ||
                                  ((dec_rd  != 5'd0) && pend[dec_rd]));
    assign stall   = !reset && (hazard || starved);
    assign wb_hold = !reset && starved;

    // Write-port mux: pipeline first unless the FIFO has been starved too long.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = '0;
        if (!reset) begin
            if (sel_pipe) begin
                rf_we = 1'b1;
                rf_wa = pipe_wa;
                rf_wd = pipe_wd;
            end else if (has_entry) begin
                rf_we = 1'b1;
                rf_wa = fifo_wa[0];
                rf_wd = fifo_wd[0];
            end
        end
    end

    // Scoreboard next state: clear on write-out, then a new issue re-sets (set wins).
    always_comb begin
        pend_nxt = pend;
        if (pop) pend_nxt[fifo_wa[0]] = 1'b0;
        if (lu_issue && (lu_issue_rd != 5'd0)) pend_nxt[lu_issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) pend <= '0;
        else       pend <= pend_nxt;
    end

    // FIFO occupancy; entry 0 is always the head.
    always_ff @(posedge clk) begin
        if (reset) count <= 2'd0;
        else       count <= count - {1'b0, pop} + {1'b0, push};
    end

    // FIFO payload; contents are don't-care while count says empty.
    always_ff @(posedge clk) begin
        if (pop) begin
            fifo_wa[0] <= fifo_wa[1];
            fifo_wd[0] <= fifo_wd[1];
        end
        if (push) begin
            fifo_wa[push_idx] <= lu_wa;
            fifo_wd[push_idx] <= lu_wd;
        end
    end

    // Starve counter: counts pipeline wins while the FIFO waits, saturating.
    always_ff @(posedge clk) begin
        if (reset || !has_entry || pop)
            starve <= '0;
        else if (sel_pipe && (starve != SW'(STARVE_LIMIT)))
            starve <= starve + SW'(1);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios followed by random traffic, every
// cycle compared against a queue-based reference model of the arbiter.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            pipe_we;
    logic [4:0]      pipe_wa;
    logic [XLEN-1:0] pipe_wd;
    logic            lu_issue;
    logic [4:0]      lu_issue_rd;
    logic            lu_valid;
    logic [4:0]      lu_wa;
    logic [XLEN-1:0] lu_wd;
    logic            lu_ready;
    logic [4:0]      dec_ra1, dec_ra2, dec_rd;
    logic            dec_valid;
    logic            stall;
    logic            wb_hold;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_rd(dec_rd), .dec_valid(dec_valid),
        .stall(stall), .wb_hold(wb_hold),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting results, a pending bit per register,
    // and the number of consecutive cycles the queue head has lost the port.
    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t       q[$];
    bit [31:0]  mpend;
    int         mstarve;
    bit         m_pop, m_pipe_won, m_ready;

    function automatic bit is_pend(input logic [4:0] r);
        return (r != 0) && mpend[r];
    endfunction

    // Settle, predict this cycle's outputs and compare.
    task automatic eval();
        bit e_we, e_hold, e_stall, hz;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        #1;
        e_we = 0; e_wa = 0; e_wd = 0; e_hold = 0; e_stall = 0;
        m_pop = 0; m_pipe_won = 0; m_ready = 0;
        if (!reset) begin
            m_ready = (q.size() < 2);
            e_hold  = (q.size() > 0) && (mstarve == LIMIT);
            if (pipe_we && pipe_wa != 0 && !e_hold) begin
                e_we = 1; e_wa = pipe_wa; e_wd = pipe_wd; m_pipe_won = 1;
            end else if (q.size() > 0) begin
                e_we = 1; e_wa = q[0].wa; e_wd = q[0].wd; m_pop = 1;
            end
            hz = dec_valid && (is_pend(dec_ra1) || is_pend(dec_ra2) || is_pend(dec_rd));
            e_stall = hz || e_hold;
        end
        check("rf_we", rf_we, e_we);
        if (e_we) begin
            check("rf_wa", rf_wa, e_wa);
            check("rf_wd", rf_wd, e_wd);
        end
        check("lu_ready", lu_ready, m_ready);
        check("wb_hold", wb_hold, e_hold);
        check("stall", stall, e_stall);
    endtask

    // Advance the model across the rising edge, return at the falling edge.
    task automatic tick();
        int sz;
        @(posedge clk);
        if (reset) begin
            q.delete();
            mpend = 0;
            mstarve = 0;
        end else begin
            sz = q.size();
            if (m_pop) begin
                mpend[q[0].wa] = 0;
                void'(q.pop_front());
            end
            if (lu_valid && m_ready && lu_wa != 0) q.push_back('{lu_wa, lu_wd});
            if (sz == 0 || m_pop) mstarve = 0;
            else if (m_pipe_won && mstarve < LIMIT) mstarve++;
            if (lu_issue && lu_issue_rd != 0) mpend[lu_issue_rd] = 1;
        end
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    task automatic idle();
        reset = 0; pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
        lu_issue = 0; lu_issue_rd = 0; lu_valid = 0; lu_wa = 0; lu_wd = 0;
        dec_valid = 0; dec_ra1 = 0; dec_ra2 = 0; dec_rd = 0;
    endtask

    initial begin
        mpend = 0; mstarve = 0;
        idle();
        reset = 1;
        @(negedge clk);

        // Reset held with traffic offered: nothing may leak out.
        lu_valid = 1; lu_wa = 5'd9; lu_wd = 32'h1234; pipe_we = 1; pipe_wa = 5'd2;
        dec_valid = 1; dec_ra1 = 5'd9;
        for (int i = 0; i < 2; i++) begin
            eval();
            check("rst_rf_we", rf_we, 0);
            check("rst_lu_ready", lu_ready, 0);
            check("rst_stall", stall, 0);
            tick();
        end
        idle();
        eval();
        check("post_rst_ready", lu_ready, 1);
        check("post_rst_we", rf_we, 0);
        tick();

        // Simple long op on x5.
        lu_issue = 1; lu_issue_rd = 5'd5; step();
        lu_issue = 0; dec_valid = 1; dec_ra1 = 5'd5;
        eval(); check("raw_stall", stall, 1); tick();
        lu_valid = 1; lu_wa = 5'd5; lu_wd = 32'hDEADBEEF; step();
        lu_valid = 0;
        eval();
        check("lu_we", rf_we, 1);
        check("lu_wa", rf_wa, 5);
        check("lu_wd", rf_wd, 32'hDEADBEEF);
        check("still_stall", stall, 1);
        tick();
        eval(); check("unstall", stall, 0); tick();
        idle();

        // Conflict: x7 waits while the pipe writes every cycle.
        lu_valid = 1; lu_wa = 5'd7; lu_wd = 32'h11; step();
        lu_valid = 0; pipe_we = 1;
        for (int r = 1; r <= 4; r++) begin
            pipe_wa = 5'(r); pipe_wd = 32'(r * 16);
            eval(); check("pipe_wins", rf_wa, 5'(r)); tick();
        end
        pipe_wa = 5'd5; pipe_wd = 32'h50;
        eval();
        check("forced_hold", wb_hold, 1);
        check("forced_wa", rf_wa, 7);
        check("forced_wd", rf_wd, 32'h11);
        tick();
        eval(); check("deferred_wa", rf_wa, 5); check("deferred_hold", wb_hold, 0); tick();

        // Full FIFO while pipe busy: x3, x4 accepted, x5 waits for a pop.
        for (int c = 0; c < 12; c++) begin
            pipe_wa = 5'(10 + c); pipe_wd = 32'(c);
            lu_valid = 1;
            lu_wa = (c == 0) ? 5'd3 : (c == 1) ? 5'd4 : 5'd5;
            lu_wd = 32'h300 + 32'(lu_wa);
            eval();
            if (c == 2) check("full_not_ready", lu_ready, 0);
            tick();
            if (c >= 2 && q.size() == 2 && q[1].wa == 5'd5) lu_valid = 0;
        end
        idle();
        for (int c = 0; c < 4; c++) step();

        // x0 never creates pending state, writes or stalls.
        lu_issue = 1; lu_issue_rd = 0; lu_valid = 1; lu_wa = 0; lu_wd = 32'hFF;
        pipe_we = 1; pipe_wa = 0; pipe_wd = 32'hEE;
        dec_valid = 1; dec_ra1 = 0; dec_ra2 = 0; dec_rd = 0;
        eval(); check("x0_we", rf_we, 0); check("x0_stall", stall, 0); tick();
        idle(); dec_valid = 1;
        eval(); check("x0_we2", rf_we, 0); check("x0_stall2", stall, 0); tick();
        idle();

        // Set/clear collision on x8.
        lu_issue = 1; lu_issue_rd = 5'd8; step();
        lu_issue = 0; lu_valid = 1; lu_wa = 5'd8; lu_wd = 32'h88; step();
        lu_valid = 0; lu_issue = 1; lu_issue_rd = 5'd8;
        eval(); check("coll_pop_wa", rf_wa, 8); tick();
        idle(); dec_valid = 1; dec_rd = 5'd8;
        eval(); check("coll_stall", stall, 1); tick();
        idle();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            pipe_we     = ($urandom_range(0, 3) != 0);
            pipe_wa     = 5'($urandom);
            pipe_wd     = $urandom;
            lu_issue    = ($urandom_range(0, 3) == 0);
            lu_issue_rd = 5'($urandom);
            lu_valid    = ($urandom_range(0, 2) == 0);
            lu_wa       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            lu_wd       = $urandom;
            dec_valid   = $urandom_range(0, 1) == 1;
            dec_ra1     = 5'($urandom);
            dec_ra2     = 5'($urandom);
            dec_rd      = 5'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
